multicycle_control_unit: RTL and testbench

Parametrised multi-cycle control FSM for the LEGv8 datapath. Replaces single-cycle opcode decode: sequences each instruction through FETCH, DECODE, EXEC, MEM and WB with ready/request handshakes to instruction and data memory. Adds a data-memory timeout, illegal-opcode detection and a retired-instruction counter. Sits between the instruction register and the datapath muxes, register file, ALU and memories.

---
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multi-cycle control FSM and the LEGv8 datapath.
// master = control unit side, slave = datapath/memory side.
interface multicycle_control_unit_if #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned CNT_W   = 16
) ();

   logic [INSTR_W-1:0] instr;
   logic               imem_ready;
   logic               dmem_ready;
   logic               imem_req;
   logic               ir_write;
   logic               pc_write;
   logic               reg_write;
   logic               mem_read;
   logic               mem_write;
   logic               mem2reg;
   logic               ALUSrc;
   logic [2:0]         alu_op;
   logic               illegal;
   logic [2:0]         state;
   logic [CNT_W-1:0]   retired_cnt;

   modport master (
      input  instr, imem_ready, dmem_ready,
      output imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, mem2reg,
             ALUSrc, alu_op, illegal, state, retired_cnt
   );

   modport slave (
      output instr, imem_ready, dmem_ready,
      input  imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, mem2reg,
             ALUSrc, alu_op, illegal, state, retired_cnt
   );

endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshakes,
// data-memory timeout, illegal-opcode detection and a retired-instruction counter.
module multicycle_control_unit #(
   parameter int unsigned INSTR_W     = 32,
   parameter int unsigned OPC_W       = 11,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   multicycle_control_unit_if.master     bus
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [OPC_W-1:0] OPC_STUR = OPC_W'(11'h7C0);
   localparam logic [OPC_W-1:0] OPC_LDUR = OPC_W'(11'h7C2);
   localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(11'h450);
   localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(11'h458);
   localparam logic [OPC_W-1:0] OPC_ORR  = OPC_W'(11'h550);
   localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(11'h658);
   localparam logic [OPC_W-1:0] OPC_MOVK = OPC_W'(11'h794);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [OPC_W-1:0]   opc_q, opc_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [OPC_W-1:0]   opc_in;
   logic               unused_instr;
   logic               is_ldur, is_stur, is_legal, timeout, retire;
   logic [2:0]         alu_sel;

   assign opc_in       = bus.instr[INSTR_W-1 -: OPC_W];
   assign unused_instr = ^bus.instr;

   assign is_ldur  = (opc_q == OPC_LDUR);
   assign is_stur  = (opc_q == OPC_STUR);
   assign is_legal = is_ldur || is_stur || (opc_q == OPC_AND) || (opc_q == OPC_ADD) ||
                     (opc_q == OPC_ORR) || (opc_q == OPC_SUB) || (opc_q == OPC_MOVK);
   // Abort on the cycle whose increment would bring the wait count to MEM_TIMEOUT.
   assign timeout  = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      alu_sel = 3'b000;
      if (opc_q == OPC_SUB)       alu_sel = 3'b001;
      else if (opc_q == OPC_AND)  alu_sel = 3'b010;
      else if (opc_q == OPC_ORR)  alu_sel = 3'b011;
      else if (opc_q == OPC_MOVK) alu_sel = 3'b100;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         opc_q   <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      wait_d  = wait_q;
      retire  = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (bus.imem_ready) begin
               opc_d   = opc_in;
               state_d = StDecode;
            end
         end
         StDecode: state_d = is_legal ? StExec : StFetch;
         StExec: begin
            if (is_ldur || is_stur) begin
               state_d = StMem;
               wait_d  = '0;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            if (bus.dmem_ready) begin
               if (is_ldur) begin
                  state_d = StWb;
               end else begin
                  state_d = StFetch;
                  retire  = 1'b1;
               end
            end else if (timeout) begin
               state_d = StFetch;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StWb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         default: state_d = StFetch;
      endcase
      cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
   end

   always_comb begin
      bus.imem_req  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem2reg   = 1'b0;
      bus.ALUSrc    = 1'b0;
      bus.alu_op    = 3'b000;
      bus.illegal   = 1'b0;
      unique case (state_q)
         StFetch: begin
            // Held low while in reset so every output reads 0 during rst_n.
            bus.imem_req = rst_n;
            bus.ir_write = rst_n & bus.imem_ready;
         end
         StDecode: begin
            bus.illegal  = ~is_legal;
            bus.pc_write = ~is_legal;
         end
         StExec: begin
            bus.alu_op  = alu_sel;
            bus.ALUSrc  = is_ldur || is_stur || (opc_q == OPC_MOVK);
            bus.mem2reg = ~is_ldur;
         end
         StMem: begin
            bus.alu_op    = alu_sel;
            bus.ALUSrc    = 1'b1;
            bus.mem2reg   = ~is_ldur;
            bus.mem_read  = is_ldur;
            bus.mem_write = is_stur;
            bus.illegal   = ~bus.dmem_ready & timeout;
            bus.pc_write  = bus.dmem_ready ? is_stur : timeout;
         end
         StWb: begin
            bus.reg_write = 1'b1;
            bus.pc_write  = 1'b1;
            bus.mem2reg   = ~is_ldur;
         end
         default: ;
      endcase
   end

   assign bus.state       = state_q;
   assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (CNT_W=4 so counter wrap is reachable).
module tb_multicycle_control_unit;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   multicycle_control_unit_if #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

   multicycle_control_unit #(
      .INSTR_W     (INSTR_W),
      .OPC_W       (11),
      .MEM_TIMEOUT (15),
      .CNT_W       (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Move to 2 time units past the next rising edge, where inputs are driven.
   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] mk(input logic [10:0] opc);
      return {opc, 21'h0A5A5};
   endfunction

   initial begin
      rst_n          = 1'b0;
      bus.instr      = '0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #3;
      chk("rst_state", bus.state, 0);
      chk("rst_cnt", bus.retired_cnt, 0);
      chk("rst_pc_write", bus.pc_write, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("post_rst_imem_req", bus.imem_req, 1);

      // ADD: 0,1,2,4,0
      adv();
      bus.instr = mk(11'h458); bus.imem_ready = 1'b1;
      #1 chk("add_fetch_irw", bus.ir_write, 1);
      adv(); bus.imem_ready = 1'b0;
      #1 chk("add_dec_state", bus.state, 1);
      chk("add_dec_pcw", bus.pc_write, 0);
      adv();
      #1 chk("add_exec_state", bus.state, 2);
      chk("add_exec_aluop", bus.alu_op, 3'b000);
      chk("add_exec_alusrc", bus.ALUSrc, 0);
      adv();
      #1 chk("add_wb_state", bus.state, 4);
      chk("add_wb_regw", bus.reg_write, 1);
      chk("add_wb_pcw", bus.pc_write, 1);
      chk("add_wb_m2r", bus.mem2reg, 1);
      adv();
      #1 chk("add_done_state", bus.state, 0);
      chk("add_cnt", bus.retired_cnt, 1);

      // LDUR with 3 wait cycles: 8 cycles total
      bus.instr = mk(11'h7C2); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0; bus.instr = mk(11'h000);
      adv();
      #1 chk("ldur_exec_alusrc", bus.ALUSrc, 1);
      chk("ldur_exec_aluop", bus.alu_op, 3'b000);
      for (int i = 0; i < 4; i++) begin
         adv();
         bus.dmem_ready = (i == 3);
         #1 chk("ldur_mem_state", bus.state, 3);
         chk("ldur_mem_read", bus.mem_read, 1);
         chk("ldur_mem_pcw", bus.pc_write, 0);
         chk("ldur_mem_m2r", bus.mem2reg, 0);
      end
      adv(); bus.dmem_ready = 1'b0;
      #1 chk("ldur_wb_state", bus.state, 4);
      chk("ldur_wb_m2r", bus.mem2reg, 0);
      chk("ldur_wb_regw", bus.reg_write, 1);
      adv();
      #1 chk("ldur_cnt", bus.retired_cnt, 2);
      chk("ldur_done_state", bus.state, 0);

      // STUR timeout: 15 MEM cycles, illegal on the last
      bus.instr = mk(11'h7C0); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0;
      adv();
      for (int i = 1; i <= 15; i++) begin
         adv();
         #1 chk("stur_to_memw", bus.mem_write, 1);
         chk("stur_to_illegal", bus.illegal, (i == 15));
         chk("stur_to_pcw", bus.pc_write, (i == 15));
      end
      adv();
      #1 chk("stur_to_state", bus.state, 0);
      chk("stur_to_cnt", bus.retired_cnt, 2);
      chk("stur_to_memw_off", bus.mem_write, 0);

      // Illegal opcode 000 caught in DECODE
      bus.instr = mk(11'h000); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0;
      #1 chk("ill_dec_illegal", bus.illegal, 1);
      chk("ill_dec_pcw", bus.pc_write, 1);
      chk("ill_dec_regw", bus.reg_write, 0);
      adv();
      #1 chk("ill_state", bus.state, 0);
      chk("ill_cnt", bus.retired_cnt, 2);

      // MOVK
      bus.instr = mk(11'h794); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0;
      adv();
      #1 chk("movk_aluop", bus.alu_op, 3'b100);
      chk("movk_alusrc", bus.ALUSrc, 1);
      adv();
      #1 chk("movk_wb_regw", bus.reg_write, 1);
      adv();
      #1 chk("movk_cnt", bus.retired_cnt, 3);

      // FETCH stall, then instr/imem_ready changes in DECODE are ignored
      bus.instr = mk(11'h458); bus.imem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 chk("stall_imem_req", bus.imem_req, 1);
         chk("stall_irw", bus.ir_write, 0);
         chk("stall_state", bus.state, 0);
         adv();
      end
      bus.instr = mk(11'h550); bus.imem_ready = 1'b1;
      adv(); bus.instr = mk(11'h658);
      #1 chk("orr_dec_irw", bus.ir_write, 0);
      adv();
      #1 chk("orr_exec_state", bus.state, 2);
      chk("orr_exec_aluop", bus.alu_op, 3'b011);
      adv(); bus.imem_ready = 1'b0;
      adv();
      #1 chk("orr_cnt", bus.retired_cnt, 4);

      // SUB and AND ALU encodings
      bus.instr = mk(11'h658); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0;
      adv();
      #1 chk("sub_aluop", bus.alu_op, 3'b001);
      adv(); adv();
      bus.instr = mk(11'h450); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0;
      adv();
      #1 chk("and_aluop", bus.alu_op, 3'b010);
      adv(); adv();
      #1 chk("and_cnt", bus.retired_cnt, 6);

      // STUR zero wait: completes from MEM
      bus.instr = mk(11'h7C0); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0;
      adv();
      adv(); bus.dmem_ready = 1'b1;
      #1 chk("stur_mem_pcw", bus.pc_write, 1);
      chk("stur_mem_illegal", bus.illegal, 0);
      chk("stur_mem_regw", bus.reg_write, 0);
      adv(); bus.dmem_ready = 1'b0;
      #1 chk("stur_state", bus.state, 0);
      chk("stur_cnt", bus.retired_cnt, 7);

      // Async reset in MEM of LDUR
      bus.instr = mk(11'h7C2); bus.imem_ready = 1'b1;
      adv(); bus.imem_ready = 1'b0;
      adv();
      adv();
      #1 chk("rst_mid_pre_state", bus.state, 3);
      rst_n = 1'b0;
      #1 chk("rst_mid_state", bus.state, 0);
      chk("rst_mid_memr", bus.mem_read, 0);
      chk("rst_mid_pcw", bus.pc_write, 0);
      chk("rst_mid_imem_req", bus.imem_req, 0);
      chk("rst_mid_cnt", bus.retired_cnt, 0);
      adv();
      rst_n = 1'b1;

      // 17 ADDs with CNT_W=4 wrap to 1
      bus.instr = mk(11'h458); bus.imem_ready = 1'b1;
      repeat (68) adv();
      bus.imem_ready = 1'b0;
      #1 chk("wrap_state", bus.state, 0);
      chk("wrap_cnt", bus.retired_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
